fpu_op_sequencer: RTL and testbench

Registered front-end for the combinational FPU datapath. Accepts operation requests (A, B, opcode) on a valid/ready interface and buffers them in a small FIFO. Drives one operation at a time onto the FPU's `A`/`B`/`Opcode` inputs and holds them stable for a fixed settle window. Then captures `Result`/`NaN_error` into a response register offered on a second valid/ready interface, so the FPU can be used as a multi-cycle path inside a synchronous system.

---
 rtl/fpu_pkg.sv | 32 +++
 rtl/fpu_req_fifo.sv | 63 ++++++
 rtl/fpu_op_sequencer.sv | 153 +++++++++++++++
 tb/tb_fpu_op_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU operation sequencer and its request FIFO.
// Also holds the NaN classification helper applied when a result is captured.
package fpu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    HOLD  = 2'b10
  } seq_state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    op_e         op;
  } fpu_req_t;

  localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
  localparam logic [31:0] QNAN         = 32'h7FC0_0000;

  // The divider raises no flag of its own, so a NaN-encoded quotient is detected here.
  function automatic logic nan_detect(input logic flag, input op_e op, input logic [31:0] result);
    return flag | ((op == OP_DIV) && (result[30:23] == EXP_ALL_ONES) && (result[22:0] != 23'd0));
  endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// Request FIFO for the FPU sequencer: DEPTH entries of fpu_req_t.
// Pointers wrap modulo DEPTH; occupancy is tracked in a separate count.
module fpu_req_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fpu_req_t                 push_data,
  input  logic                     pop,
  output fpu_req_t                 pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  fpu_req_t          mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [PW:0]       count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (count_r == (PW+1)'(DEPTH));
  assign empty     = (count_r == (PW+1)'(0));
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage is not reset: only count_r decides which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= (PW+1)'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Registered front-end for a combinational FPU: queues requests, holds operands for
// SETTLE cycles, then offers the captured result on a valid/ready response port.
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [1:0]  req_op,
  output logic [31:0] fpu_A,
  output logic [31:0] fpu_B,
  output logic [1:0]  fpu_Opcode,
  input  logic [31:0] fpu_Result,
  input  logic        fpu_NaN_error,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_nan,
  output logic [1:0]  rsp_op,
  output logic        busy
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int QW = $clog2(DEPTH) + 1;

  seq_state_e     state_r;
  seq_state_e     state_next_s;
  logic [CW-1:0]  settle_cnt_r;
  logic [CW-1:0]  settle_cnt_next_s;
  logic           pop_s;
  logic           capture_s;
  logic           push_s;
  fpu_req_t       req_s;
  fpu_req_t       head_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic [QW-1:0]  fifo_count_s;

  logic [31:0]    fpu_a_r;
  logic [31:0]    fpu_b_r;
  op_e            fpu_op_r;
  logic           rsp_valid_r;
  logic [31:0]    rsp_result_r;
  logic           rsp_nan_r;
  op_e            rsp_op_r;

  assign req_ready = !fifo_full_s;
  assign push_s    = req_valid && req_ready;
  assign req_s     = '{a: req_a, b: req_b, op: op_e'(req_op)};

  fpu_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (req_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Next-state logic: a pop always reloads the settle window and enters DRIVE.
  always_comb begin
    state_next_s      = state_r;
    settle_cnt_next_s = settle_cnt_r;
    pop_s             = 1'b0;
    capture_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s             = 1'b1;
          settle_cnt_next_s = CW'(SETTLE - 1);
          state_next_s      = DRIVE;
        end else begin
          state_next_s      = IDLE;
        end
      end
      DRIVE: begin
        if (settle_cnt_r == CW'(0)) begin
          capture_s         = 1'b1;
          state_next_s      = HOLD;
        end else begin
          settle_cnt_next_s = settle_cnt_r - CW'(1);
          state_next_s      = DRIVE;
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          if (!fifo_empty_s) begin
            pop_s             = 1'b1;
            settle_cnt_next_s = CW'(SETTLE - 1);
            state_next_s      = DRIVE;
          end else begin
            state_next_s      = IDLE;
          end
        end else begin
          state_next_s      = HOLD;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, operand and response registers; reset discards any in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      settle_cnt_r <= CW'(0);
      fpu_a_r      <= 32'h0000_0000;
      fpu_b_r      <= 32'h0000_0000;
      fpu_op_r     <= OP_ADD;
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= 32'h0000_0000;
      rsp_nan_r    <= 1'b0;
      rsp_op_r     <= OP_ADD;
    end else begin
      state_r      <= state_next_s;
      settle_cnt_r <= settle_cnt_next_s;
      rsp_valid_r  <= (state_next_s == HOLD);
      if (pop_s) begin
        fpu_a_r  <= head_s.a;
        fpu_b_r  <= head_s.b;
        fpu_op_r <= head_s.op;
      end
      if (capture_s) begin
        rsp_result_r <= fpu_Result;
        rsp_op_r     <= fpu_op_r;
        rsp_nan_r    <= nan_detect(fpu_NaN_error, fpu_op_r, fpu_Result);
      end
    end
  end

  assign fpu_A      = fpu_a_r;
  assign fpu_B      = fpu_b_r;
  assign fpu_Opcode = fpu_op_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = rsp_result_r;
  assign rsp_nan    = rsp_nan_r;
  assign rsp_op     = rsp_op_r;
  assign busy       = (state_r != IDLE) || (fifo_count_s != QW'(0));

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer with a table-driven stand-in FPU.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fpu_op_sequencer;
  import fpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [1:0]  req_op;
  logic [31:0] fpu_A;
  logic [31:0] fpu_B;
  logic [1:0]  fpu_Opcode;
  logic [31:0] fpu_Result;
  logic        fpu_NaN_error;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_nan;
  logic [1:0]  rsp_op;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;
  int n;

  fpu_op_sequencer #(.DEPTH(4), .SETTLE(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_op        (req_op),
    .fpu_A         (fpu_A),
    .fpu_B         (fpu_B),
    .fpu_Opcode    (fpu_Opcode),
    .fpu_Result    (fpu_Result),
    .fpu_NaN_error (fpu_NaN_error),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_nan       (rsp_nan),
    .rsp_op        (rsp_op),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in FPU: a few exact IEEE cases, otherwise A^B with no flag.
  always_comb begin
    fpu_Result    = fpu_A ^ fpu_B;
    fpu_NaN_error = 1'b0;
    if (fpu_Opcode == 2'b00 && fpu_A == 32'h3F80_0000 && fpu_B == 32'h4000_0000) begin
      fpu_Result = 32'h4040_0000;
    end else if (fpu_Opcode == 2'b11 && fpu_A == 32'h0000_0000 && fpu_B == 32'h0000_0000) begin
      fpu_Result = QNAN;
    end else if (fpu_Opcode == 2'b11 && fpu_A == 32'h3F80_0000 && fpu_B == 32'h0000_0000) begin
      fpu_Result = 32'h7F80_0000;
    end else if (fpu_Opcode == 2'b00 && fpu_A == 32'h7FC0_0000) begin
      fpu_Result    = QNAN;
      fpu_NaN_error = 1'b1;
    end else begin
      fpu_Result    = fpu_A ^ fpu_B;
      fpu_NaN_error = 1'b0;
    end
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [31:0] exp_res, input logic exp_nan);
    int lat;
    push(a, b, op);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check32({tag, "_latency"}, 32'(lat), 32'd4);
    check32({tag, "_result"}, rsp_result, exp_res);
    check1({tag, "_nan"}, rsp_nan, exp_nan);
    check32({tag, "_op"}, 32'(rsp_op), 32'(op));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check1({tag, "_valid_drop"}, rsp_valid, 1'b0);
  endtask

  task automatic collect(input string tag, input logic [31:0] exp_res);
    int w;
    w = 0;
    while (!rsp_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check1({tag, "_valid"}, rsp_valid, 1'b1);
    check32({tag, "_result"}, rsp_result, exp_res);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = 32'h0000_0000;
    req_b     = 32'h0000_0000;
    req_op    = 2'b00;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    check1("rst_req_ready", req_ready, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check32("rst_fpu_A", fpu_A, 32'h0000_0000);
    check32("rst_rsp_result", rsp_result, 32'h0000_0000);

    // Single add with cycle-by-cycle checks
    req_valid = 1'b1;
    req_a     = 32'h3F80_0000;
    req_b     = 32'h4000_0000;
    req_op    = 2'b00;
    @(negedge clk);
    req_valid = 1'b0;
    check1("add_c1_busy", busy, 1'b1);
    check32("add_c1_fpu_A", fpu_A, 32'h0000_0000);
    @(negedge clk);
    check32("add_c2_fpu_A", fpu_A, 32'h3F80_0000);
    check32("add_c2_fpu_B", fpu_B, 32'h4000_0000);
    check1("add_c2_valid", rsp_valid, 1'b0);
    @(negedge clk);
    check1("add_c3_valid", rsp_valid, 1'b0);
    @(negedge clk);
    check1("add_c4_valid", rsp_valid, 1'b1);
    check32("add_c4_result", rsp_result, 32'h4040_0000);
    check1("add_c4_nan", rsp_nan, 1'b0);
    check32("add_c4_op", 32'(rsp_op), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check1("add_c5_valid", rsp_valid, 1'b0);
    check1("add_c5_busy", busy, 1'b0);

    // NaN rule
    run_one("div_0_0", 32'h0000_0000, 32'h0000_0000, 2'b11, QNAN, 1'b1);
    run_one("div_1_0", 32'h3F80_0000, 32'h0000_0000, 2'b11, 32'h7F80_0000, 1'b0);
    run_one("add_nan_flag", 32'h7FC0_0000, 32'h3F80_0000, 2'b00, QNAN, 1'b1);
    run_one("mul_nan_noflag", 32'h7FC0_0001, 32'h0000_0000, 2'b10, 32'h7FC0_0001, 1'b0);

    // Backpressure with three queued requests
    push(32'h1111_0000, 32'h0000_0001, 2'b00);
    push(32'h2222_0000, 32'h0000_0002, 2'b01);
    push(32'h3333_0000, 32'h0000_0003, 2'b10);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check1("bp_first_valid", rsp_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check1($sformatf("bp_hold_valid_%0d", i), rsp_valid, 1'b1);
      check32($sformatf("bp_hold_result_%0d", i), rsp_result, 32'h1111_0001);
      check32($sformatf("bp_hold_op_%0d", i), 32'(rsp_op), 32'd0);
      check32($sformatf("bp_hold_fpu_A_%0d", i), fpu_A, 32'h1111_0000);
      @(negedge clk);
    end
    check32("bp_r1_result", rsp_result, 32'h1111_0001);
    rsp_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check1($sformatf("bp_rel_valid_%0d", i), rsp_valid, (i % 3) == 0);
      if (i == 3) begin
        check32("bp_r2_result", rsp_result, 32'h2222_0002);
        check32("bp_r2_op", 32'(rsp_op), 32'd1);
      end
      if (i == 6) begin
        check32("bp_r3_result", rsp_result, 32'h3333_0003);
        check32("bp_r3_op", 32'(rsp_op), 32'd2);
        check32("bp_r3_fpu_A", fpu_A, 32'h3333_0000);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    check1("bp_end_valid", rsp_valid, 1'b0);
    check1("bp_end_busy", busy, 1'b0);

    // Full FIFO while HOLD is stalled
    push(32'hA000_0000, 32'h0000_0100, 2'b01);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check1("full_q0_valid", rsp_valid, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      push(32'hA000_0000 + 32'(k), 32'h0000_0100, 2'b01);
      check1($sformatf("full_ready_after_%0d", k), req_ready, k < 4);
    end
    req_valid = 1'b1;
    req_a     = 32'hA000_0005;
    req_b     = 32'h0000_0100;
    req_op    = 2'b01;
    repeat (3) begin
      @(negedge clk);
      check1("full_stall_ready", req_ready, 1'b0);
    end
    check32("full_q0_result", rsp_result, 32'hA000_0100);
    rsp_ready = 1'b1;
    @(negedge clk);
    check1("full_ready_after_pop", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    check1("full_refilled_ready", req_ready, 1'b0);
    collect("full_q1", 32'hA000_0101);
    collect("full_q2", 32'hA000_0102);
    collect("full_q3", 32'hA000_0103);
    collect("full_q4", 32'hA000_0104);
    collect("full_q5", 32'hA000_0105);
    repeat (4) begin
      @(negedge clk);
      check1("full_no_dup_valid", rsp_valid, 1'b0);
    end
    check1("full_end_busy", busy, 1'b0);
    rsp_ready = 1'b0;

    // Reset in DRIVE with two requests queued
    push(32'hC000_0001, 32'h0000_0010, 2'b00);
    push(32'hC000_0002, 32'h0000_0010, 2'b00);
    push(32'hC000_0003, 32'h0000_0010, 2'b00);
    check32("rstmid_drive_fpu_A", fpu_A, 32'hC000_0001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check1("rstmid_valid", rsp_valid, 1'b0);
    check1("rstmid_busy", busy, 1'b0);
    check1("rstmid_req_ready", req_ready, 1'b1);
    check32("rstmid_fpu_A", fpu_A, 32'h0000_0000);
    check32("rstmid_rsp_result", rsp_result, 32'h0000_0000);
    repeat (5) begin
      @(negedge clk);
      check1("rstmid_quiet_valid", rsp_valid, 1'b0);
      check1("rstmid_quiet_busy", busy, 1'b0);
    end
    run_one("post_rst_add", 32'h3F80_0000, 32'h4000_0000, 2'b00, 32'h4040_0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
